spram_nport_arb: RTL and testbench



---
 rtl/spram_nport_arb.sv | 150 +++++++++++++++
 tb/tb_spram_nport_arb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/spram_nport_arb.sv
// Shared single-port RAM, time-sliced among NCH req/ack clients; optional macro SPRAM_FIXED_PRIO_EN.
// Latency: ack one cycle after req, read data/rvalid two cycles after req; one RAM access per clock.
// Backpressure: a client holds its request until ack; the channel in stage 1 is ineligible (max 1 access per 2 clocks).
module spram_nport_arb #(
   parameter int AW  = 10,
   parameter int DW  = 32,
   parameter int BW  = 8,
   parameter int NCH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NCH-1:0]            ch_req,
   input  logic [NCH-1:0]            ch_we,
   input  logic [NCH*AW-1:0]         ch_addr,
   input  logic [NCH*DW-1:0]         ch_di,
   input  logic [NCH*(DW/BW)-1:0]    ch_be,
   output logic [NCH-1:0]            ch_ack,
   output logic [NCH-1:0]            ch_rvalid,
   output logic [NCH*DW-1:0]         ch_do
);

   localparam int NB = DW / BW;
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   // One latched access travelling from arbitration to the RAM.
   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] di;
      logic [NB-1:0] be;
   } acc_t;

   logic           s1_vld;
   logic [CW-1:0]  s1_ch;
   acc_t           s1_dat;

   logic [NCH-1:0] elig;
   logic           win_vld;
   logic [CW-1:0]  win_ch;
   acc_t           win_dat;

   logic [DW-1:0]  mem [2**AW];
   logic [DW-1:0]  rd_dat;

   // A channel whose access is already in stage 1 cannot be granted again;
   // this is what turns a still-high req in the ack cycle into a harmless no-op.
   always_comb begin
      elig = '0;
      for (int k = 0; k < NCH; k++) begin
         elig[k] = ch_req[k] && !(s1_vld && (s1_ch == CW'(k)));
      end
   end

`ifdef SPRAM_FIXED_PRIO_EN
   // Fixed priority: lowest-index eligible channel wins (highest index scanned first, overwritten by lower).
   always_comb begin
      win_vld = 1'b0;
      win_ch  = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (elig[k]) begin
            win_vld = 1'b1;
            win_ch  = CW'(k);
         end
      end
   end
`else
   logic [CW-1:0] rr_ptr;

   // Round-robin: scan offsets far-to-near from rr_ptr so the nearest eligible channel after rr_ptr wins last.
   always_comb begin
      win_vld = 1'b0;
      win_ch  = '0;
      for (int off = NCH; off >= 1; off--) begin
         for (int k = 0; k < NCH; k++) begin
            if ((k == (int'(rr_ptr) + off) % NCH) && elig[k]) begin
               win_vld = 1'b1;
               win_ch  = CW'(k);
            end
         end
      end
   end

   // Pointer remembers the last granted channel; reset value makes channel 0 win first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= CW'(NCH - 1);
      end else if (win_vld) begin
         rr_ptr <= win_ch;
      end
   end
`endif

   // Mux the winning channel's request fields into one access record.
   always_comb begin
      win_dat = '0;
      for (int k = 0; k < NCH; k++) begin
         if (win_ch == CW'(k)) begin
            win_dat = {ch_we[k], ch_addr[k*AW +: AW], ch_di[k*DW +: DW], ch_be[k*NB +: NB]};
         end
      end
   end

   // Arbitration edge: latch the winner into stage 1 and pulse its ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_ch  <= '0;
         s1_dat <= '0;
         ch_ack <= '0;
      end else begin
         s1_vld <= win_vld;
         if (win_vld) begin
            s1_ch  <= win_ch;
            s1_dat <= win_dat;
         end
         for (int k = 0; k < NCH; k++) begin
            ch_ack[k] <= win_vld && (win_ch == CW'(k));
         end
      end
   end

   // RAM write with byte lanes; s1_vld is cleared asynchronously, so reset drops a pending write.
   always_ff @(posedge clk) begin
      if (s1_vld && s1_dat.we) begin
         for (int i = 0; i < NB; i++) begin
            if (s1_dat.be[i]) begin
               mem[s1_dat.addr][i*BW +: BW] <= s1_dat.di[i*BW +: BW];
            end
         end
      end
   end

   assign rd_dat = mem[s1_dat.addr];

   // Access edge: reads land in the owning channel's held data register with a one-cycle rvalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_rvalid <= '0;
         ch_do     <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            ch_rvalid[k] <= s1_vld && !s1_dat.we && (s1_ch == CW'(k));
            if (s1_vld && !s1_dat.we && (s1_ch == CW'(k))) begin
               ch_do[k*DW +: DW] <= rd_dat;
            end
         end
      end
   end

endmodule

// File: tb/tb_spram_nport_arb.sv
// Bench for spram_nport_arb: 2-channel data path checks and 3-channel arbitration order.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Arbitration expectations follow SPRAM_FIXED_PRIO_EN when that macro is defined.
module tb_spram_nport_arb;

   logic        clk;
   logic        rst_n;

   logic [1:0]  req2, we2, ack2, rv2;
   logic [19:0] addr2;
   logic [63:0] di2, do2;
   logic [7:0]  be2;

   logic [2:0]  req3, we3, ack3, rv3;
   logic [29:0] addr3;
   logic [95:0] di3, do3;
   logic [11:0] be3;

   int n_chk = 0;
   int n_err = 0;

   spram_nport_arb #(.AW(10), .DW(32), .BW(8), .NCH(2)) u2 (
      .clk(clk), .rst_n(rst_n), .ch_req(req2), .ch_we(we2), .ch_addr(addr2),
      .ch_di(di2), .ch_be(be2), .ch_ack(ack2), .ch_rvalid(rv2), .ch_do(do2)
   );

   spram_nport_arb #(.AW(10), .DW(32), .BW(8), .NCH(3)) u3 (
      .clk(clk), .rst_n(rst_n), .ch_req(req3), .ch_we(we3), .ch_addr(addr3),
      .ch_di(di3), .ch_be(be3), .ch_ack(ack3), .ch_rvalid(rv3), .ch_do(do3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access on the 2-channel instance; waits (bounded) for ack, and for reads checks rvalid and data.
   // Returns in the ack cycle for writes, in the rvalid cycle for reads.
   task automatic u2_op(input int ch, input logic we, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] exp, input string tag);
      int n;
      req2[ch]            = 1'b1;
      we2[ch]             = we;
      addr2[ch*10 +: 10]  = a;
      di2[ch*32 +: 32]    = d;
      be2[ch*4 +: 4]      = be;
      n = 0;
      do begin
         tick();
         n++;
      end while (!ack2[ch] && n < 8);
      chk({tag, "_ack"}, {62'd0, ack2}, 64'd1 << ch);
      req2[ch] = 1'b0;
      if (!we) begin
         tick();
         chk({tag, "_rv"}, {62'd0, rv2}, 64'd1 << ch);
         chk({tag, "_do"}, {32'd0, do2[ch*32 +: 32]}, {32'd0, exp});
      end
   endtask

   logic [2:0] exp_rr [6];

   initial begin
      rst_n = 1'b0;
      req2 = '0; we2 = '0; addr2 = '0; di2 = '0; be2 = '0;
      req3 = '0; we3 = '0; addr3 = '0; di3 = '0; be3 = '0;
`ifdef SPRAM_FIXED_PRIO_EN
      exp_rr = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`else
      exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
      tick();
      tick();
      chk("rst_ack2", {62'd0, ack2}, 64'd0);
      chk("rst_rv2",  {62'd0, rv2},  64'd0);
      chk("rst_do2",  do2, 64'd0);
      chk("rst_ack3", {61'd0, ack3}, 64'd0);
      chk("rst_do3",  do3[63:0], 64'd0);
      rst_n = 1'b1;

      // t0: ch0 full write 0x005 = DEADBEEF
      req2[0] = 1'b1; we2[0] = 1'b1; addr2[9:0] = 10'h005; di2[31:0] = 32'hDEADBEEF; be2[3:0] = 4'hF;
      tick();                                      // t1
      chk("wr_ack_t1", {62'd0, ack2}, 64'd1);
      tick();                                      // t2
      chk("wr_noack_t2", {62'd0, ack2}, 64'd0);
      chk("wr_norv_t2",  {62'd0, rv2},  64'd0);
      we2[0] = 1'b0;                               // t2: ch0 read 0x005
      tick();                                      // t3
      chk("rd_ack_t3", {62'd0, ack2}, 64'd1);
      chk("rd_norv_t3", {62'd0, rv2}, 64'd0);
      tick();                                      // t4
      chk("rd_rv_t4",  {62'd0, rv2}, 64'd1);
      chk("rd_do0_t4", {32'd0, do2[31:0]}, 64'h00000000DEADBEEF);
      chk("rd_do1_t4", {32'd0, do2[63:32]}, 64'd0);
      chk("rd_noack_t4", {62'd0, ack2}, 64'd0);
      req2[0] = 1'b0;

      // Partial write from ch1 into lane 1 only, read back through ch0.
      u2_op(1, 1'b1, 10'h005, 32'h00001200, 4'h2, 32'h0, "pw_wr");
      tick();
      u2_op(0, 1'b0, 10'h005, 32'h0, 4'h0, 32'hDEAD12EF, "pw_rd");
      chk("pw_do1_held", {32'd0, do2[63:32]}, 64'd0);

      // Read-after-write across channels: ch0 read issued in ch1's ack cycle.
      u2_op(1, 1'b1, 10'h3FF, 32'h12345678, 4'hF, 32'h0, "raw_wr");
      u2_op(0, 1'b0, 10'h3FF, 32'h0, 4'h0, 32'h12345678, "raw_rd");

      // Reset in the middle of a write: the committed old value must survive.
      u2_op(0, 1'b1, 10'h010, 32'h11112222, 4'hF, 32'h0, "pre_wr");
      tick();
      req2[0] = 1'b1; we2[0] = 1'b1; addr2[9:0] = 10'h010; di2[31:0] = 32'hAAAA5555; be2[3:0] = 4'hF;
      tick();
      chk("mid_ack", {62'd0, ack2}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", {62'd0, ack2}, 64'd0);
      chk("mid_rst_rv",  {62'd0, rv2},  64'd0);
      chk("mid_rst_do",  do2, 64'd0);
      req2 = '0; we2 = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      u2_op(0, 1'b0, 10'h010, 32'h0, 4'h0, 32'h11112222, "post_rd");

      // Three channels reading continuously: one ack per cycle in arbitration order.
      req3 = 3'b111; we3 = 3'b000;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("arb3_%0d", i), {61'd0, ack3}, {61'd0, exp_rr[i]});
      end
      // Channel 0 alone: granted every other cycle.
      req3 = 3'b001;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("solo_%0d", i), {61'd0, ack3}, (i % 2 == 0) ? 64'd1 : 64'd0);
      end
      req3 = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
